// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; define VGA_TIMING_SHADOW_EN to latch timing at frame start
module vga_timing_gen #(
   parameter int BITS_PER_COLOR = 4,
   parameter int HW = 12,
   parameter int VW = 12
) (
   input  logic                        i_pixclk,
   input  logic                        i_reset,
   input  logic [HW-1:0]               i_hm_width,
   input  logic [HW-1:0]               i_hm_porch,
   input  logic [HW-1:0]               i_hm_synch,
   input  logic [HW-1:0]               i_hm_raw,
   input  logic [VW-1:0]               i_vm_height,
   input  logic [VW-1:0]               i_vm_porch,
   input  logic [VW-1:0]               i_vm_synch,
   input  logic [VW-1:0]               i_vm_raw,
   input  logic [3*BITS_PER_COLOR-1:0] i_pixel,
   output logic                        o_rd,
   output logic                        o_newline,
   output logic                        o_newframe,
   output logic                        o_vga_hsync,
   output logic                        o_vga_vsync,
   output logic [BITS_PER_COLOR-1:0]   o_vga_red,
   output logic [BITS_PER_COLOR-1:0]   o_vga_green,
   output logic [BITS_PER_COLOR-1:0]   o_vga_blue
);

   localparam int BPC = BITS_PER_COLOR;
   localparam logic [HW-1:0] H_ONE = HW'(1);
   localparam logic [VW-1:0] V_ONE = VW'(1);

   logic [HW-1:0] h_width, h_porch, h_synch, h_raw;
   logic [VW-1:0] v_height, v_porch, v_synch, v_raw;

`ifdef VGA_TIMING_SHADOW_EN
   logic          first_q, first_d;
   logic [HW-1:0] sh_h_width_q, sh_h_porch_q, sh_h_synch_q, sh_h_raw_q;
   logic [HW-1:0] sh_h_width_d, sh_h_porch_d, sh_h_synch_d, sh_h_raw_d;
   logic [VW-1:0] sh_v_height_q, sh_v_porch_q, sh_v_synch_q, sh_v_raw_q;
   logic [VW-1:0] sh_v_height_d, sh_v_porch_d, sh_v_synch_d, sh_v_raw_d;

   // The first cycle after reset runs on the live inputs since the shadows are not loaded yet.
   always_comb begin
      first_d       = 1'b0;
      sh_h_width_d  = sh_h_width_q;
      sh_h_porch_d  = sh_h_porch_q;
      sh_h_synch_d  = sh_h_synch_q;
      sh_h_raw_d    = sh_h_raw_q;
      sh_v_height_d = sh_v_height_q;
      sh_v_porch_d  = sh_v_porch_q;
      sh_v_synch_d  = sh_v_synch_q;
      sh_v_raw_d    = sh_v_raw_q;
      if (first_q || o_newframe) begin
         sh_h_width_d  = i_hm_width;
         sh_h_porch_d  = i_hm_porch;
         sh_h_synch_d  = i_hm_synch;
         sh_h_raw_d    = i_hm_raw;
         sh_v_height_d = i_vm_height;
         sh_v_porch_d  = i_vm_porch;
         sh_v_synch_d  = i_vm_synch;
         sh_v_raw_d    = i_vm_raw;
      end
      if (first_q) begin
         h_width  = i_hm_width;
         h_porch  = i_hm_porch;
         h_synch  = i_hm_synch;
         h_raw    = i_hm_raw;
         v_height = i_vm_height;
         v_porch  = i_vm_porch;
         v_synch  = i_vm_synch;
         v_raw    = i_vm_raw;
      end else begin
         h_width  = sh_h_width_q;
         h_porch  = sh_h_porch_q;
         h_synch  = sh_h_synch_q;
         h_raw    = sh_h_raw_q;
         v_height = sh_v_height_q;
         v_porch  = sh_v_porch_q;
         v_synch  = sh_v_synch_q;
         v_raw    = sh_v_raw_q;
      end
   end

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         first_q       <= 1'b1;
         sh_h_width_q  <= '0;
         sh_h_porch_q  <= '0;
         sh_h_synch_q  <= '0;
         sh_h_raw_q    <= '0;
         sh_v_height_q <= '0;
         sh_v_porch_q  <= '0;
         sh_v_synch_q  <= '0;
         sh_v_raw_q    <= '0;
      end else begin
         first_q       <= first_d;
         sh_h_width_q  <= sh_h_width_d;
         sh_h_porch_q  <= sh_h_porch_d;
         sh_h_synch_q  <= sh_h_synch_d;
         sh_h_raw_q    <= sh_h_raw_d;
         sh_v_height_q <= sh_v_height_d;
         sh_v_porch_q  <= sh_v_porch_d;
         sh_v_synch_q  <= sh_v_synch_d;
         sh_v_raw_q    <= sh_v_raw_d;
      end
   end
`else
   always_comb begin
      h_width  = i_hm_width;
      h_porch  = i_hm_porch;
      h_synch  = i_hm_synch;
      h_raw    = i_hm_raw;
      v_height = i_vm_height;
      v_porch  = i_vm_porch;
      v_synch  = i_vm_synch;
      v_raw    = i_vm_raw;
   end
`endif

   logic [HW-1:0]  hpos_q, hpos_d;
   logic [VW-1:0]  vpos_q, vpos_d;
   logic           de_d1_q, de_d1_d;
   logic           hs_d1_q, hs_d1_d, hs_d2_q, hs_d2_d;
   logic           vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
   logic [BPC-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic           h_end, v_end, hsync_raw, vsync_raw;

   // Greater-or-equal end tests let a counter stranded past a shrunken total wrap at once.
   always_comb begin
      h_end      = hpos_q >= (h_raw - H_ONE);
      v_end      = vpos_q >= (v_raw - V_ONE);
      o_rd       = (hpos_q < h_width) && (vpos_q < v_height);
      o_newline  = h_end;
      o_newframe = h_end && v_end;
      hsync_raw  = !((hpos_q >= h_porch) && (hpos_q < h_synch));
      vsync_raw  = !((vpos_q >= v_porch) && (vpos_q < v_synch));

      hpos_d = hpos_q + H_ONE;
      vpos_d = vpos_q;
      if (h_end) begin
         hpos_d = '0;
         vpos_d = v_end ? '0 : vpos_q + V_ONE;
      end

      de_d1_d = o_rd;
      hs_d1_d = hsync_raw;
      hs_d2_d = hs_d1_q;
      vs_d1_d = vsync_raw;
      vs_d2_d = vs_d1_q;
      red_d   = de_d1_q ? i_pixel[3*BPC-1 -: BPC] : '0;
      green_d = de_d1_q ? i_pixel[2*BPC-1 -: BPC] : '0;
      blue_d  = de_d1_q ? i_pixel[BPC-1:0] : '0;
   end

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         hpos_q  <= '0;
         vpos_q  <= '0;
         de_d1_q <= 1'b0;
         hs_d1_q <= 1'b1;
         hs_d2_q <= 1'b1;
         vs_d1_q <= 1'b1;
         vs_d2_q <= 1'b1;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end else begin
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         de_d1_q <= de_d1_d;
         hs_d1_q <= hs_d1_d;
         hs_d2_q <= hs_d2_d;
         vs_d1_q <= vs_d1_d;
         vs_d2_q <= vs_d2_d;
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
      end
   end

   assign o_vga_hsync = hs_d2_q;
   assign o_vga_vsync = vs_d2_q;
   assign o_vga_red   = red_q;
   assign o_vga_green = green_q;
   assign o_vga_blue  = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] hm_width, hm_porch, hm_synch, hm_raw;
   logic [11:0] vm_height, vm_porch, vm_synch, vm_raw;
   logic [11:0] pixel;
   logic        rd, newline, newframe, hsync, vsync;
   logic [3:0]  red, green, blue;

   int n_checks = 0;
   int n_fail   = 0;
   int mw, mp, ms, mr, vh, vp, vs, vr;
   logic [11:0] pix_hist [0:4095];

   vga_timing_gen #(.BITS_PER_COLOR(4), .HW(12), .VW(12)) dut (
      .i_pixclk(clk), .i_reset(rst),
      .i_hm_width(hm_width), .i_hm_porch(hm_porch), .i_hm_synch(hm_synch), .i_hm_raw(hm_raw),
      .i_vm_height(vm_height), .i_vm_porch(vm_porch), .i_vm_synch(vm_synch), .i_vm_raw(vm_raw),
      .i_pixel(pixel), .o_rd(rd), .o_newline(newline), .o_newframe(newframe),
      .o_vga_hsync(hsync), .o_vga_vsync(vsync),
      .o_vga_red(red), .o_vga_green(green), .o_vga_blue(blue)
   );

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic set_mode(input int w, input int p, input int s, input int r,
                           input int h, input int q, input int t, input int u);
      mw = w; mp = p; ms = s; mr = r; vh = h; vp = q; vs = t; vr = u;
      hm_width = 12'(w); hm_porch = 12'(p); hm_synch = 12'(s); hm_raw = 12'(r);
      vm_height = 12'(h); vm_porch = 12'(q); vm_synch = 12'(t); vm_raw = 12'(u);
   endtask

   // Leaves the bench at the negedge where reset drops: cycle 0 of the raster.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Raster model: position of cycle n is plain modular arithmetic on the cycle count.
   function automatic bit m_rd(int n);
      if (n < 0) return 1'b0;
      return ((n % mr) < mw) && (((n / mr) % vr) < vh);
   endfunction

   function automatic bit m_hs(int n);
      int h;
      if (n < 2) return 1'b1;
      h = (n - 2) % mr;
      return !(h >= mp && h < ms);
   endfunction

   function automatic bit m_vs(int n);
      int v;
      if (n < 2) return 1'b1;
      v = ((n - 2) / mr) % vr;
      return !(v >= vp && v < vs);
   endfunction

   task automatic test_reset();
      set_mode(8, 10, 12, 14, 4, 5, 6, 7);
      pixel = 12'hABC;
      rst = 1'b1;
      #3;
      if ({red, green, blue} !== 12'h000) begin
         $display("FAIL reset_colour got=%h exp=000", {red, green, blue}); n_fail++;
      end
      n_checks++;
      if ({hsync, vsync} !== 2'b11) begin
         $display("FAIL reset_syncs got=%b exp=11", {hsync, vsync}); n_fail++;
      end
      n_checks++;
      repeat (3) @(posedge clk);
      #1;
      if ({red, green, blue, hsync, vsync} !== 14'b11) begin
         $display("FAIL reset_held got=%h exp=0003", {red, green, blue, hsync, vsync}); n_fail++;
      end
      n_checks++;
      if ({rd, newline, newframe} !== 3'b100) begin
         $display("FAIL reset_strobes got=%b exp=100", {rd, newline, newframe}); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_line_timing();
      set_mode(8, 10, 12, 14, 4, 5, 6, 7);
      do_reset();
      for (int n = 0; n < 28; n++) begin
         if (n > 0) @(negedge clk);
         #1;
         if (rd !== ((n % 14) < 8)) begin
            $display("FAIL line_rd cyc=%0d got=%b exp=%b", n, rd, (n % 14) < 8); n_fail++;
         end
         n_checks++;
         if (newline !== ((n % 14) == 13)) begin
            $display("FAIL line_newline cyc=%0d got=%b exp=%b", n, newline, (n % 14) == 13); n_fail++;
         end
         n_checks++;
         if (hsync !== !((n % 14) == 12 || (n % 14) == 13)) begin
            $display("FAIL line_hsync cyc=%0d got=%b", n, hsync); n_fail++;
         end
         n_checks++;
      end
   endtask

   task automatic test_frame_timing();
      set_mode(8, 10, 12, 14, 4, 5, 6, 7);
      do_reset();
      for (int n = 0; n < 200; n++) begin
         if (n > 0) @(negedge clk);
         #1;
         if (newframe !== ((n % 98) == 97)) begin
            $display("FAIL frame_newframe cyc=%0d got=%b exp=%b", n, newframe, (n % 98) == 97); n_fail++;
         end
         n_checks++;
         if (newframe === 1'b1 && newline !== 1'b1) begin
            $display("FAIL frame_without_line cyc=%0d got=%b exp=1", n, newline); n_fail++;
         end
         n_checks++;
         if (vsync !== !((n % 98) >= 72 && (n % 98) <= 85)) begin
            $display("FAIL frame_vsync cyc=%0d got=%b", n, vsync); n_fail++;
         end
         n_checks++;
      end
   endtask

   task automatic test_pixel_latency();
      logic [11:0] exp;
      set_mode(8, 10, 12, 14, 4, 5, 6, 7);
      pixel = 12'hABC;
      do_reset();
      for (int n = 0; n < 110; n++) begin
         if (n > 0) @(negedge clk);
         #1;
         exp = ((n % 14) >= 2 && (n % 14) <= 9 && ((n / 14) % 7) < 4) ? 12'hABC : 12'h000;
         if ({red, green, blue} !== exp) begin
            $display("FAIL pixel_latency cyc=%0d got=%h exp=%h", n, {red, green, blue}, exp); n_fail++;
         end
         n_checks++;
      end
   endtask

   // Random pixels on the reference mode, then random legal modes.
   task automatic test_random_model();
      int w, p, s, r, h, q, t, u, ncyc;
      logic [11:0] exp_col;
      for (int it = 0; it < 4; it++) begin
         if (it == 0) begin
            set_mode(8, 10, 12, 14, 4, 5, 6, 7);
         end else begin
            w = $urandom_range(1, 8); p = w + $urandom_range(0, 3);
            s = p + $urandom_range(0, 3); r = s + $urandom_range(1, 3);
            h = $urandom_range(1, 4); q = h + $urandom_range(0, 3);
            t = q + $urandom_range(0, 3); u = t + $urandom_range(1, 3);
            set_mode(w, p, s, r, h, q, t, u);
         end
         ncyc = 2 * mr * vr + 5;
         do_reset();
         for (int n = 0; n < ncyc; n++) begin
            if (n > 0) @(negedge clk);
            pix_hist[n] = 12'($urandom);
            pixel = pix_hist[n];
            #1;
            exp_col = (n >= 2 && m_rd(n - 2)) ? pix_hist[n-1] : 12'h000;
            if (rd !== m_rd(n)) begin
               $display("FAIL model_rd it=%0d cyc=%0d got=%b exp=%b", it, n, rd, m_rd(n)); n_fail++;
            end
            n_checks++;
            if (newline !== ((n % mr) == mr - 1)) begin
               $display("FAIL model_newline it=%0d cyc=%0d got=%b", it, n, newline); n_fail++;
            end
            n_checks++;
            if (newframe !== ((n % (mr * vr)) == mr * vr - 1)) begin
               $display("FAIL model_newframe it=%0d cyc=%0d got=%b", it, n, newframe); n_fail++;
            end
            n_checks++;
            if (hsync !== m_hs(n) || vsync !== m_vs(n)) begin
               $display("FAIL model_syncs it=%0d cyc=%0d got=%b%b exp=%b%b", it, n, hsync, vsync, m_hs(n), m_vs(n)); n_fail++;
            end
            n_checks++;
            if ({red, green, blue} !== exp_col) begin
               $display("FAIL model_colour it=%0d cyc=%0d got=%h exp=%h", it, n, {red, green, blue}, exp_col); n_fail++;
            end
            n_checks++;
         end
      end
   endtask

   task automatic test_mode_change();
      bit exp;
      set_mode(8, 10, 12, 14, 4, 5, 6, 7);
      do_reset();
`ifdef VGA_TIMING_SHADOW_EN
      for (int n = 0; n < 140; n++) begin
         if (n > 0) @(negedge clk);
         #1;
         exp = (n <= 97) ? ((n % 14) == 13) : (((n - 98) % 16) == 15);
         if (newline !== exp) begin
            $display("FAIL shadow_newline cyc=%0d got=%b exp=%b", n, newline, exp); n_fail++;
         end
         n_checks++;
         if (n == 20) hm_raw = 12'd16;
      end
`else
      for (int n = 0; n < 60; n++) begin
         if (n > 0) @(negedge clk);
         #1;
         exp = (n < 14) ? (n == 13) : (((n - 14) % 16) == 15);
         if (newline !== exp) begin
            $display("FAIL live_grow_newline cyc=%0d got=%b exp=%b", n, newline, exp); n_fail++;
         end
         n_checks++;
         if (n == 20) hm_raw = 12'd16;
      end
      hm_raw = 12'd14;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         if (n > 0) @(negedge clk);
         #1;
         exp = (n < 27) ? ((n % 14) == 13) : (((n - 27) % 10) == 9);
         if (newline !== exp) begin
            $display("FAIL shrink_newline cyc=%0d got=%b exp=%b", n, newline, exp); n_fail++;
         end
         n_checks++;
         if (n == 26) begin
            hm_raw = 12'd10;
            #1;
            if (newline !== 1'b1) begin
               $display("FAIL shrink_same_cycle got=%b exp=1", newline); n_fail++;
            end
            n_checks++;
         end
         if (n == 27) begin
            if (rd !== 1'b1) begin
               $display("FAIL shrink_wrap_rd got=%b exp=1", rd); n_fail++;
            end
            n_checks++;
         end
      end
      hm_raw = 12'd14;
`endif
   endtask

   task automatic test_mid_line_reset();
      int points [2] = '{5, 13};
      set_mode(8, 10, 12, 14, 4, 5, 6, 7);
      pixel = 12'hABC;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         for (int n = 1; n <= points[k]; n++) @(negedge clk);
         #1;
         if (k == 0 && {red, green, blue} !== 12'hABC) begin
            $display("FAIL midreset_pre_colour got=%h exp=abc", {red, green, blue}); n_fail++;
         end
         if (k == 1 && {hsync, newline} !== 2'b01) begin
            $display("FAIL midreset_pre_sync got=%b exp=01", {hsync, newline}); n_fail++;
         end
         n_checks++;
         #1;
         rst = 1'b1;
         #1;
         if ({red, green, blue} !== 12'h000) begin
            $display("FAIL midreset_colour pt=%0d got=%h exp=000", points[k], {red, green, blue}); n_fail++;
         end
         n_checks++;
         if ({hsync, vsync} !== 2'b11) begin
            $display("FAIL midreset_syncs pt=%0d got=%b exp=11", points[k], {hsync, vsync}); n_fail++;
         end
         n_checks++;
         if ({rd, newline, newframe} !== 3'b100) begin
            $display("FAIL midreset_position pt=%0d got=%b exp=100", points[k], {rd, newline, newframe}); n_fail++;
         end
         n_checks++;
      end
   endtask

   initial begin
      rst = 1'b1;
      pixel = 12'h000;
      set_mode(8, 10, 12, 14, 4, 5, 6, 7);
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_pixel_latency();
      test_random_model();
      test_mode_change();
      test_mid_line_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter BITS_PER_COLOR, default 4, giving bits per colour channel (BPC).
REQ-002 SHALL have parameter HW, default 12, giving the width of the horizontal timing fields.
REQ-003 SHALL have parameter VW, default 12, giving the width of the vertical timing fields.
REQ-004 SHALL have port i_pixclk  in  1  pixel clock; the only clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw  in  HW each  visible width, sync start, sync end, total line length.
REQ-007 SHALL have ports i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw  in  VW each  visible height, sync start, sync end, total frame length.
REQ-008 SHALL have port i_pixel  in  3*BPC  pixel from the pattern source, ordered {R,G,B}, valid one cycle after o_rd.
REQ-009 SHALL have ports o_rd, o_newline, o_newframe  out  1 each  pixel request, line-start strobe, frame-start strobe to the source.
REQ-010 SHALL have ports o_vga_hsync, o_vga_vsync  out  1 each  active-low syncs.
REQ-011 SHALL have ports o_vga_red, o_vga_green, o_vga_blue  out  BPC each  colour outputs.

Function
REQ-012 SHALL keep hpos (HW bits) and vpos (VW bits); hpos increments every cycle; when hpos >= hraw-1, hpos becomes 0 and vpos increments; when vpos >= vraw-1 at that point, vpos also becomes 0.
REQ-013 SHALL use >= comparisons so that a counter beyond a newly reduced total wraps on the next clock and never runs to 2^HW.
REQ-014 SHALL drive o_rd combinationally as (hpos < width) && (vpos < height).
REQ-015 SHALL drive o_newline combinationally high exactly in the cycle where hpos >= hraw-1, so the source sees it one cycle before the first o_rd of the line.
REQ-016 SHALL drive o_newframe high only where o_newline is high and vpos >= vraw-1; o_newframe never asserts without o_newline.
REQ-017 SHALL compute raw hsync low for porch <= hpos < synch and raw vsync low for porch <= vpos < synch.
REQ-018 SHALL delay raw hsync and vsync by exactly 2 register stages to o_vga_hsync and o_vga_vsync.
REQ-019 SHALL register o_rd into de_d1; on each clock, load the colour outputs from the corresponding i_pixel fields when de_d1 = 1, else load 0.
REQ-020 SHALL therefore give colour and sync a total latency of 2 cycles after the o_rd cycle, aligned with each other.
REQ-021 SHALL require 0 < width <= porch <= synch <= raw for correct timing, per axis; behaviour outside that range is limited to REQ-013 wrap.

Reset
REQ-022 SHALL, while i_reset = 1 and independent of the clock, set hpos=0, vpos=0, de_d1=0, both sync pipelines to 1, and all colour outputs to 0.
REQ-023 SHALL, after reset release, start counting from (0,0) on the first clock; o_rd is high in that cycle if width and height are nonzero, and the source is expected to be reset by the same i_reset.
REQ-024 SHALL, on reset asserted mid-line or mid-frame, abort immediately with no partial-line completion.

Configuration
REQ-025 SHALL, with macro VGA_TIMING_SHADOW_EN defined, compare against shadow copies of all eight timing inputs.
REQ-026 SHALL load the shadow copies on the first clock after reset release and on each clock where o_newframe = 1, so mode changes take effect at frame start only.
REQ-027 SHALL, without VGA_TIMING_SHADOW_EN, use the live inputs directly so that changes take effect on the next clock.

Verification
Mode for all scenarios: width/porch/synch/raw = 8/10/12/14 and height/porch/synch/raw = 4/5/6/7.
REQ-028 SHALL cover line timing: release reset -> o_rd=1 in cycles 0-7; o_newline in cycle 13; o_vga_hsync low in cycles 12-13.
REQ-029 SHALL cover frame timing: run from reset -> o_newframe only in cycle 97, together with o_newline; o_vga_vsync low during line 5, delayed 2 cycles.
REQ-030 SHALL cover pixel latency: i_pixel = 12'hABC held -> red/green/blue = A/B/C in cycles 2-9 of each visible line and 0 elsewhere.
REQ-031 SHALL cover shadow loading: with the macro, set i_hm_raw = 16 at cycle 20 -> lines stay 14 cycles until cycle 97, then 16; without the macro, the current line lasts 16 cycles.
REQ-032 SHALL cover live shrink: without the macro, at hpos = 12 set i_hm_raw = 10 -> o_newline in the same cycle and hpos = 0 on the next clock.
REQ-033 SHALL cover mid-line reset: assert i_reset at hpos = 5 between clock edges -> colour outputs = 0 and syncs = 1 immediately, with no further clock edge required.
